map_encoder: RTL and testbench



---
 rtl/map_encoder.sv | 145 ++++++++++++++
 tb/tb_map_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/map_encoder.sv
// Collects a 5x7 pixel map one column per cycle, then searches the eight known
// map patterns sequentially and returns the matching map code over valid/ready.
module map_encoder #(
    parameter int unsigned DATA_WIDTH    = 35,
    parameter int unsigned COLUNE_SIZE   = 7,
    parameter int unsigned TOTAL_COLUNES = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   col_valid,
    input  logic                   col_first,
    input  logic [COLUNE_SIZE-1:0] col_data,
    output logic                   col_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             code_out,
    output logic                   match,
    output logic [DATA_WIDTH-1:0]  map_out,
    output logic                   busy
);

    localparam int unsigned IDX_W = 3;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(TOTAL_COLUNES - 1);
    localparam logic [2:0]       LAST_CAND = 3'd7;

    // Known map patterns, indexed by map code.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [2:0] code);
        logic [DATA_WIDTH-1:0] p;
        case (code)
            3'd0:    p = DATA_WIDTH'(35'h1C7FFFDF0);
            3'd1:    p = DATA_WIDTH'(35'h6FB37ECEF);
            3'd2:    p = DATA_WIDTH'(35'h7FBFFFFFF);
            3'd3:    p = DATA_WIDTH'(35'h07A7DE7FF);
            3'd4:    p = DATA_WIDTH'(35'h7DDBBB26F);
            3'd5:    p = DATA_WIDTH'(35'h5FA1F73F7);
            3'd6:    p = DATA_WIDTH'(35'h63BAEEEE3);
            default: p = DATA_WIDTH'(35'h1BF726DFF);
        endcase
        return p;
    endfunction

    logic [1:0]            state_q,     state_d;
    logic [IDX_W-1:0]      col_idx_q,   col_idx_d;
    logic [2:0]            cand_q,      cand_d;
    logic [DATA_WIDTH-1:0] map_q,       map_d;
    logic [2:0]            code_q,      code_d;
    logic                  match_q,     match_d;
    logic                  out_valid_q, out_valid_d;
    logic                  col_ready_q, col_ready_d;
    logic                  busy_q,      busy_d;
    logic [IDX_W-1:0]      slot;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cand_d    = cand_q;
        map_d     = map_q;
        code_d    = code_q;
        match_d   = match_q;
        slot      = '0;

        case (state_q)
            ST_COLLECT: begin
                if (col_valid && col_ready_q) begin
                    // col_first always resynchronises to slice 0.
                    slot = col_first ? '0 : col_idx_q;
                    for (int j = 0; j < int'(TOTAL_COLUNES); j++) begin
                        if (slot == IDX_W'(j))
                            map_d[j*COLUNE_SIZE +: COLUNE_SIZE] = col_data;
                    end
                    if (col_first) begin
                        col_idx_d = IDX_W'(1);
                    end else if (col_idx_q == LAST_COL) begin
                        state_d   = ST_SEARCH;
                        col_idx_d = '0;
                        cand_d    = '0;
                    end else begin
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SEARCH: begin
                if (map_q == pattern(cand_q)) begin
                    code_d  = cand_q;
                    match_d = 1'b1;
                    state_d = ST_RESULT;
                end else if (cand_q == LAST_CAND) begin
                    code_d  = 3'd0;
                    match_d = 1'b0;
                    state_d = ST_RESULT;
                end else begin
                    cand_d = cand_q + 3'd1;
                end
            end
            ST_RESULT: begin
                if (out_valid_q && out_ready)
                    state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase

        // out_valid rises one cycle after entering RESULT and holds until taken.
        out_valid_d = (state_q == ST_RESULT) && (state_d == ST_RESULT);
        col_ready_d = (state_d == ST_COLLECT);
        busy_d      = (state_d != ST_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            col_idx_q   <= '0;
            cand_q      <= '0;
            map_q       <= '0;
            code_q      <= '0;
            match_q     <= 1'b0;
            out_valid_q <= 1'b0;
            col_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            cand_q      <= cand_d;
            map_q       <= map_d;
            code_q      <= code_d;
            match_q     <= match_d;
            out_valid_q <= out_valid_d;
            col_ready_q <= col_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign col_ready = col_ready_q;
    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign match     = match_q;
    assign map_out   = map_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_map_encoder.sv
// Self-checking bench for map_encoder: random gaps, random maps and back-pressure,
// checked against a table-lookup reference model with spec-level latency rules.
module tb_map_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        col_valid;
    logic        col_first;
    logic [6:0]  col_data;
    logic        col_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  code_out;
    logic        match;
    logic [34:0] map_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [34:0] table_p [8] = '{35'h1C7FFFDF0, 35'h6FB37ECEF, 35'h7FBFFFFFF, 35'h07A7DE7FF,
                                 35'h7DDBBB26F, 35'h5FA1F73F7, 35'h63BAEEEE3, 35'h1BF726DFF};

    map_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_valid (col_valid),
        .col_first (col_first),
        .col_data  (col_data),
        .col_ready (col_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .match     (match),
        .map_out   (map_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: first table entry equal to the map, and its report latency.
    function automatic void ref_model(input logic [34:0] m, output logic [2:0] code,
                                      output logic hit, output int lat);
        code = 3'd0;
        hit  = 1'b0;
        lat  = 9;
        for (int k = 7; k >= 0; k--) begin
            if (table_p[k] == m) begin
                code = 3'(k);
                hit  = 1'b1;
                lat  = 2 + k;
            end
        end
    endfunction

    task automatic send_col(input logic [6:0] d, input logic first);
        int n;
        @(negedge clk);
        col_valid = 1'b1;
        col_first = first;
        col_data  = d;
        n = 0;
        while (!col_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (col_ready !== 1'b1) begin
            errors++;
            $display("FAIL col_accept: col_ready=%b required 1 (timeout)", col_ready);
        end
        @(posedge clk);
    endtask

    task automatic finish_cols();
        @(negedge clk);
        col_valid = 1'b0;
        col_first = 1'b0;
    endtask

    task automatic send_map(input logic [34:0] m, input int maxgap);
        for (int c = 0; c < 5; c++) begin
            send_col(m[c*7 +: 7], c == 0);
            if (c < 4) begin
                int g;
                g = int'($urandom_range(maxgap, 0));
                for (int i = 0; i < g; i++) begin
                    @(negedge clk);
                    col_valid = 1'b0;
                    col_first = 1'b0;
                end
            end
        end
        finish_cols();
    endtask

    // Entered on the negedge right after the last column's accepting edge.
    task automatic wait_result(input string name, input logic [34:0] m, input int hold);
        logic [2:0] ec;
        logic       eh;
        int         el;
        int         n;
        ref_model(m, ec, eh, el);
        n = 0;
        while (!out_valid && n < 40) begin
            checks++;
            if (col_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s search_flags: col_ready=%b busy=%b required 0/1", name, col_ready, busy);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != el) begin
            errors++;
            $display("FAIL %s latency: %0d cycles required %0d", name, n, el);
        end
        checks++;
        if (code_out !== ec || match !== eh) begin
            errors++;
            $display("FAIL %s result: code=%0d match=%b required %0d/%b", name, code_out, match, ec, eh);
        end
        checks++;
        if (map_out !== m) begin
            errors++;
            $display("FAIL %s map_out: %h required %h", name, map_out, m);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            col_valid = 1'b1;
            col_data  = 7'($urandom);
            checks++;
            if (out_valid !== 1'b1 || code_out !== ec || match !== eh || col_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold: valid=%b code=%0d match=%b col_ready=%b busy=%b required 1/%0d/%b/0/1",
                         name, out_valid, code_out, match, col_ready, busy, ec, eh);
            end
        end
        @(negedge clk);
        col_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || col_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: valid=%b col_ready=%b busy=%b required 0/1/0",
                     name, out_valid, col_ready, busy);
        end
        checks++;
        if (map_out !== m) begin
            errors++;
            $display("FAIL %s map_hold: %h required %h", name, map_out, m);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        col_valid = 1'b0;
        col_first = 1'b0;
        col_data  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (col_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            map_out !== 35'h0 || code_out !== 3'd0 || match !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b busy=%b map=%h code=%0d match=%b required 1/0/0/0/0/0",
                     col_ready, out_valid, busy, map_out, code_out, match);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_map(table_p[0], 0);
        wait_result("basic_p0", table_p[0], 0);
    endtask

    task automatic test_backpressure();
        send_map(table_p[5], 0);
        wait_result("backpressure_p5", table_p[5], 4);
    endtask

    task automatic test_no_match();
        send_map(35'h0, 1);
        wait_result("nomatch_zero", 35'h0, 1);
        send_map(table_p[7], 1);
        wait_result("last_p7", table_p[7], 0);
    endtask

    task automatic test_resync();
        logic [34:0] junk;
        junk = {3'($urandom), 32'($urandom)};
        for (int c = 0; c < 3; c++) send_col(junk[c*7 +: 7], c == 0);
        for (int c = 0; c < 5; c++) send_col(table_p[4][c*7 +: 7], c == 0);
        finish_cols();
        wait_result("resync_p4", table_p[4], 1);
    endtask

    task automatic test_all_patterns();
        for (int k = 0; k < 8; k++) begin
            send_map(table_p[k], 3);
            wait_result($sformatf("gaps_p%0d", k), table_p[k], int'($urandom_range(2, 0)));
        end
    endtask

    task automatic test_random_maps();
        for (int i = 0; i < 8; i++) begin
            logic [34:0] m;
            if ($urandom_range(1, 0) == 1) m = table_p[$urandom_range(7, 0)];
            else m = {3'($urandom), 32'($urandom)};
            send_map(m, 2);
            wait_result($sformatf("random_%0d", i), m, int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_reset_mid_search();
        send_map(table_p[6], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || map_out !== 35'h0 || col_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b map=%h ready=%b busy=%b required 0/0/1/0",
                     out_valid, map_out, col_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_map(table_p[6], 1);
        wait_result("after_reset_p6", table_p[6], 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_no_match();
        test_resync();
        test_all_patterns();
        test_random_maps();
        test_reset_mid_search();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
